// File: rtl/display_source_arbiter.sv
// display_source_arbiter: fixed-priority selection of one BCD counter source
// with a minimum dwell time, registered digit latch and time-multiplexed
// digit scan for a shared 7-segment decoder.
module display_source_arbiter #(
   parameter int unsigned N_SRC       = 4,
   parameter int unsigned DIGITS      = 3,
   parameter int unsigned HOLD_CYCLES = 1000,
   parameter int unsigned SCAN_DIV    = 50000,
   localparam int unsigned SW         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_SRC-1:0]          req,
   input  logic [N_SRC*DIGITS*4-1:0] src_data,
   output logic [SW-1:0]             sel_src,
   output logic                      valid,
   output logic [DIGITS*4-1:0]       sel_digits,
   output logic [DIGITS-1:0]         scan_en,
   output logic [3:0]                scan_digit,
   output logic                      multi_req,
   output logic                      bcd_err
);

   localparam int unsigned DW = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
   localparam int unsigned CW = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned SLICE_W = DIGITS * 4;

   localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] SCAN_LAST   = CW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DIG_LAST    = DW'(DIGITS - 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [SW-1:0]        src_q, src_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic                 valid_q, valid_d;
   logic [SLICE_W-1:0]   digits_q, digits_d;
   logic                 bcd_err_q, bcd_err_d;
   logic                 multi_q, multi_d;
   logic [CW-1:0]        scan_cnt_q, scan_cnt_d;
   logic [DW-1:0]        dig_q, dig_d;
   logic [DIGITS-1:0]    scan_en_q, scan_en_d;
   logic [3:0]           scan_digit_q, scan_digit_d;

   logic [SW-1:0]        winner;
   logic                 any_req;
   logic [SLICE_W-1:0]   live;
   logic [3:0]           nib;

   // Priority encoder: lowest requesting index wins.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (req[i]) begin
            winner  = SW'(i);
            any_req = 1'b1;
         end
      end
   end

   // Arbitration FSM: lock, dwell countdown, release and preemption.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      hold_d  = hold_q;
      multi_d = ($countones(req) > 1);
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d = ST_LOCKED;
               src_d   = winner;
               hold_d  = HOLD_RELOAD;
            end
         end
         ST_LOCKED: begin
            if (!req[src_q]) begin
               // Own request dropped: dwell is abandoned.
               if (any_req) begin
                  src_d  = winner;
                  hold_d = HOLD_RELOAD;
               end else begin
                  state_d = ST_IDLE;
                  src_d   = '0;
                  hold_d  = '0;
               end
            end else if ((hold_q == '0) && (winner < src_q)) begin
               src_d  = winner;
               hold_d = HOLD_RELOAD;
            end else if (hold_q != '0) begin
               hold_d = hold_q - HW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            src_d   = '0;
            hold_d  = '0;
         end
      endcase
      valid_d = (state_d == ST_LOCKED);
   end

   // Digit latch: follow the selected source live, blanking non-BCD nibbles.
   always_comb begin
      live      = '0;
      nib       = 4'h0;
      digits_d  = '1;
      bcd_err_d = 1'b0;
      for (int k = 0; k < int'(N_SRC); k++) begin
         if (src_d == SW'(k)) begin
            live = src_data[k*SLICE_W +: SLICE_W];
         end
      end
      if (state_d == ST_LOCKED) begin
         for (int d = 0; d < int'(DIGITS); d++) begin
            nib = live[d*4 +: 4];
            if (nib > 4'd9) begin
               digits_d[d*4 +: 4] = 4'hF;
               bcd_err_d          = 1'b1;
            end else begin
               digits_d[d*4 +: 4] = nib;
            end
         end
      end
   end

   // Scan timing and digit drive; the divider free-runs even when idle.
   always_comb begin
      scan_cnt_d   = scan_cnt_q + CW'(1);
      dig_d        = dig_q;
      scan_en_d    = '0;
      scan_digit_d = 4'hF;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         dig_d      = (dig_q == DIG_LAST) ? '0 : dig_q + DW'(1);
      end
      if (valid_q) begin
         scan_en_d[dig_q] = 1'b1;
         scan_digit_d     = digits_q[int'(dig_q)*4 +: 4];
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         src_q        <= '0;
         hold_q       <= '0;
         valid_q      <= 1'b0;
         digits_q     <= '1;
         bcd_err_q    <= 1'b0;
         multi_q      <= 1'b0;
         scan_cnt_q   <= '0;
         dig_q        <= '0;
         scan_en_q    <= '0;
         scan_digit_q <= 4'hF;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         hold_q       <= hold_d;
         valid_q      <= valid_d;
         digits_q     <= digits_d;
         bcd_err_q    <= bcd_err_d;
         multi_q      <= multi_d;
         scan_cnt_q   <= scan_cnt_d;
         dig_q        <= dig_d;
         scan_en_q    <= scan_en_d;
         scan_digit_q <= scan_digit_d;
      end
   end

   assign sel_src    = src_q;
   assign valid      = valid_q;
   assign sel_digits = digits_q;
   assign scan_en    = scan_en_q;
   assign scan_digit = scan_digit_q;
   assign multi_req  = multi_q;
   assign bcd_err    = bcd_err_q;

endmodule
